// File: rtl/sevenseg_scan_driver_if.sv
// sevenseg_scan_driver_if: value inputs and display-pin outputs of the scan driver
interface sevenseg_scan_driver_if;
  logic        load;
  logic [15:0] bcd_in;
  logic [3:0]  dp_in;
  logic        blank_lz;
  logic [3:0]  anode_n;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic [1:0]  digit_idx;
  logic        frame_done;
  modport master (
    output load, bcd_in, dp_in, blank_lz,
    input  anode_n, seg_n, dp_n, digit_idx, frame_done
  );
  modport slave (
    input  load, bcd_in, dp_in, blank_lz,
    output anode_n, seg_n, dp_n, digit_idx, frame_done
  );
endinterface

// File: rtl/sevenseg_scan_driver.sv
// sevenseg_scan_driver: double-buffered 4-digit multiplexed seven-segment scanner
module sevenseg_scan_driver #(
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 1000
) (
  input logic                   clk,
  input logic                   rst_n,
  sevenseg_scan_driver_if.slave dsp_io
);
  localparam int CW = $clog2(SCAN_DIV);
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   sh_bcd_q, sh_bcd_d, act_bcd_q, act_bcd_d;
  logic [3:0]    sh_dp_q, sh_dp_d, act_dp_q, act_dp_d;
  logic          pend_q, pend_d;
  logic [3:0]    anode_q, anode_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic          fd_q, fd_d;
  logic          slot_end, boundary, blanked, show;
  logic [3:0]    nib;
  logic [15:0]   upper;
  function automatic logic [6:0] dec(input logic [3:0] n);
    case (n)
      4'd0:    dec = 7'b1000000;
      4'd1:    dec = 7'b1111001;
      4'd2:    dec = 7'b0100100;
      4'd3:    dec = 7'b0110000;
      4'd4:    dec = 7'b0011001;
      4'd5:    dec = 7'b0010010;
      4'd6:    dec = 7'b0000010;
      4'd7:    dec = 7'b1111000;
      4'd8:    dec = 7'b0000000;
      4'd9:    dec = 7'b0010000;
      default: dec = 7'b0111111;
    endcase
  endfunction
  // Next scan position, buffer transfer, and the outputs for the next cycle's scan position
  always_comb begin
    slot_end  = int'(cnt_q) == SCAN_DIV - 1;
    boundary  = slot_end && idx_q == 2'd3;
    cnt_d     = slot_end ? '0 : cnt_q + 1'b1;
    idx_d     = idx_q + {1'b0, slot_end};
    sh_bcd_d  = (dsp_io.load && !boundary) ? dsp_io.bcd_in : sh_bcd_q;
    sh_dp_d   = (dsp_io.load && !boundary) ? dsp_io.dp_in : sh_dp_q;
    pend_d    = boundary ? 1'b0 : (dsp_io.load | pend_q);
    act_bcd_d = !boundary ? act_bcd_q : dsp_io.load ? dsp_io.bcd_in : pend_q ? sh_bcd_q : act_bcd_q;
    act_dp_d  = !boundary ? act_dp_q : dsp_io.load ? dsp_io.dp_in : pend_q ? sh_dp_q : act_dp_q;
    nib       = act_bcd_d[{idx_d, 2'b00} +: 4];
    upper     = act_bcd_d >> {idx_d, 2'b00};
    blanked   = idx_d != 2'd0 && dsp_io.blank_lz && upper == 16'd0 && !act_dp_d[idx_d];
    show      = int'(cnt_d) >= BLANK_CYC && !blanked;
    anode_d   = show ? ~(4'b0001 << idx_d) : 4'hF;
    seg_d     = show ? dec(nib) : 7'h7F;
    dp_d      = show ? ~act_dp_d[idx_d] : 1'b1;
    fd_d      = boundary;
  end
  // State and registered outputs, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      idx_q     <= '0;
      sh_bcd_q  <= '0;
      sh_dp_q   <= '0;
      act_bcd_q <= '0;
      act_dp_q  <= '0;
      pend_q    <= 1'b0;
      anode_q   <= 4'hF;
      seg_q     <= 7'h7F;
      dp_q      <= 1'b1;
      fd_q      <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      sh_bcd_q  <= sh_bcd_d;
      sh_dp_q   <= sh_dp_d;
      act_bcd_q <= act_bcd_d;
      act_dp_q  <= act_dp_d;
      pend_q    <= pend_d;
      anode_q   <= anode_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
      fd_q      <= fd_d;
    end
  end
  assign dsp_io.anode_n    = anode_q;
  assign dsp_io.seg_n      = seg_q;
  assign dsp_io.dp_n       = dp_q;
  assign dsp_io.digit_idx  = idx_q;
  assign dsp_io.frame_done = fd_q;
endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// tb_sevenseg_scan_driver: table vectors, corner sequences and random traffic against a time-based model
module tb_sevenseg_scan_driver;
  localparam int SD = 8;
  localparam int BC = 2;
  localparam int FR = 4 * SD;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  sevenseg_scan_driver_if bus();
  sevenseg_scan_driver #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut (.clk(clk), .rst_n(rst_n), .dsp_io(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic [15:0] bcd;
    logic [3:0]  dp;
    logic        blz;
    int          digit;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dpn;
  } rec_t;
  rec_t        tab[12];
  logic [6:0]  seg_tab[16];
  int          vectors = 0;
  int          miscompares = 0;
  int          t = 0;
  logic [15:0] m_act = '0, m_sh = '0;
  logic [3:0]  m_adp = '0, m_sdp = '0;
  logic        m_pend = 1'b0;
  logic [14:0] exp_v;
  logic        blz_r = 1'b0;
  int          fd_cnt;
  function automatic logic [14:0] got();
    return {bus.anode_n, bus.seg_n, bus.dp_n, bus.digit_idx, bus.frame_done};
  endfunction
  function automatic logic [14:0] model_out(input logic blz);
    int s, ph;
    logic bl, fd;
    logic [15:0] up;
    s  = (t / SD) % 4;
    ph = t % SD;
    up = m_act >> (4 * s);
    bl = s != 0 && blz && up == 16'd0 && !m_adp[s];
    fd = t > 0 && t % FR == 0;
    if (ph >= BC && !bl)
      return {~(4'b0001 << s), seg_tab[m_act[4*s +: 4]], ~m_adp[s], 2'(s), fd};
    return {4'hF, 7'h7F, 1'b1, 2'(s), fd};
  endfunction
  task automatic chk(input string nm, input logic [14:0] g, input logic [14:0] e);
    vectors++;
    if (g !== e) begin
      miscompares++;
      $display("FAIL %s t=%0d got=%h expected=%h", nm, t, g, e);
    end
  endtask
  task automatic cyc(input logic l, input logic [15:0] b, input logic [3:0] d, input logic blz, input logic rn);
    bus.load = l;
    bus.bcd_in = b;
    bus.dp_in = d;
    bus.blank_lz = blz;
    rst_n = rn;
    @(posedge clk);
    if (!rn) begin
      t = 0; m_act = '0; m_sh = '0; m_adp = '0; m_sdp = '0; m_pend = 1'b0;
    end else begin
      t++;
      if (t % FR == 0) begin
        if (l) begin
          m_act = b; m_adp = d; m_pend = 1'b0;
        end else if (m_pend) begin
          m_act = m_sh; m_adp = m_sdp; m_pend = 1'b0;
        end
      end else if (l) begin
        m_sh = b; m_sdp = d; m_pend = 1'b1;
      end
    end
    exp_v = model_out(blz);
    #1;
    chk("model", got(), exp_v);
  endtask
  task automatic run_to(input int digit, input int ph, input logic blz);
    int n;
    n = 0;
    while (!((t / SD) % 4 == digit && t % SD == ph) && n < 40) begin
      cyc(1'b0, 16'h0, 4'h0, blz, 1'b1);
      n++;
    end
    if (n >= 40) begin
      vectors++;
      miscompares++;
      $display("FAIL run_to timeout digit=%0d phase=%0d", digit, ph);
    end
  endtask
  initial begin
    seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000,
                7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111};
    tab[0]  = '{16'h1234, 4'b0000, 1'b0, 0, 4'b1110, 7'b0011001, 1'b1};
    tab[1]  = '{16'h1234, 4'b0000, 1'b0, 3, 4'b0111, 7'b1111001, 1'b1};
    tab[2]  = '{16'h0050, 4'b0000, 1'b1, 3, 4'b1111, 7'b1111111, 1'b1};
    tab[3]  = '{16'h0050, 4'b0000, 1'b1, 2, 4'b1111, 7'b1111111, 1'b1};
    tab[4]  = '{16'h0050, 4'b0000, 1'b1, 1, 4'b1101, 7'b0010010, 1'b1};
    tab[5]  = '{16'h0050, 4'b0000, 1'b1, 0, 4'b1110, 7'b1000000, 1'b1};
    tab[6]  = '{16'h0050, 4'b0000, 1'b0, 3, 4'b0111, 7'b1000000, 1'b1};
    tab[7]  = '{16'h00A0, 4'b0010, 1'b0, 1, 4'b1101, 7'b0111111, 1'b0};
    tab[8]  = '{16'h0000, 4'b0000, 1'b1, 0, 4'b1110, 7'b1000000, 1'b1};
    tab[9]  = '{16'h0000, 4'b0000, 1'b1, 1, 4'b1111, 7'b1111111, 1'b1};
    tab[10] = '{16'h0002, 4'b0100, 1'b1, 2, 4'b1011, 7'b1000000, 1'b0};
    tab[11] = '{16'h9876, 4'b1000, 1'b1, 3, 4'b0111, 7'b0010000, 1'b0};
    repeat (3) cyc(1'b0, 16'h0, 4'h0, 1'b0, 1'b0);
    chk("reset", got(), {4'hF, 7'h7F, 1'b1, 2'd0, 1'b0});
    for (int i = 0; i < 12; i++) begin
      cyc(1'b1, tab[i].bcd, tab[i].dp, tab[i].blz, 1'b1);
      run_to(0, 0, tab[i].blz);
      run_to(tab[i].digit, 4, tab[i].blz);
      chk($sformatf("table%0d", i), got(), {tab[i].an, tab[i].seg, tab[i].dpn, 2'(tab[i].digit), 1'b0});
    end
    cyc(1'b1, 16'h1234, 4'h0, 1'b0, 1'b1);
    run_to(0, 0, 1'b0);
    run_to(1, 3, 1'b0);
    cyc(1'b1, 16'h5678, 4'h0, 1'b0, 1'b1);
    run_to(2, 4, 1'b0);
    chk("tear_d2", got(), {4'b1011, 7'b0100100, 1'b1, 2'd2, 1'b0});
    run_to(3, 4, 1'b0);
    chk("tear_d3", got(), {4'b0111, 7'b1111001, 1'b1, 2'd3, 1'b0});
    run_to(0, 0, 1'b0);
    chk("tear_fd", got(), {4'hF, 7'h7F, 1'b1, 2'd0, 1'b1});
    run_to(0, 4, 1'b0);
    chk("tear_new", got(), {4'b1110, 7'b0000000, 1'b1, 2'd0, 1'b0});
    run_to(3, 7, 1'b0);
    cyc(1'b1, 16'h0007, 4'b0001, 1'b0, 1'b1);
    run_to(0, 4, 1'b0);
    chk("boundary_load", got(), {4'b1110, 7'b1111000, 1'b0, 2'd0, 1'b0});
    fd_cnt = 0;
    for (int i = 0; i < 2 * FR; i++) begin
      cyc(1'b0, 16'h0, 4'h0, 1'b0, 1'b1);
      if (bus.frame_done) fd_cnt++;
    end
    chk("fd_count", 15'(fd_cnt), 15'd2);
    run_to(2, 4, 1'b0);
    cyc(1'b0, 16'h0, 4'h0, 1'b0, 1'b0);
    chk("mid_rst", got(), {4'hF, 7'h7F, 1'b1, 2'd0, 1'b0});
    cyc(1'b0, 16'h0, 4'h0, 1'b0, 1'b1);
    chk("post_rst_blank", got(), {4'hF, 7'h7F, 1'b1, 2'd0, 1'b0});
    cyc(1'b0, 16'h0, 4'h0, 1'b0, 1'b1);
    chk("post_rst_zero", got(), {4'b1110, 7'b1000000, 1'b1, 2'd0, 1'b0});
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 49) == 0) blz_r = ~blz_r;
      cyc($urandom_range(0, 15) == 0, 16'($urandom), 4'($urandom), blz_r, $urandom_range(0, 399) != 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
